nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
Sequencer that computes one WIDTH-bit add or subtract by time-multiplexing a single external 4-bit combinational adder, one nibble per cycle, LSB nibble first. It rippling the carry through a registered carry flop. It accepts operands on a valid/ready input handshake, drives the shared 4-bit adder's operand and carry-in pins, and collects sum nibbles. It presents the result on a valid/ready output handshake. It sits between operand producers and the existing 4-bit adder, trading latency for area.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8 (elaboration error otherwise)
NUM_NIB, WIDTH/4, derived (localparam): number of adder passes
CNT_W, clog2(NUM_NIB), derived (localparam): nibble index counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand request valid
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in for add; ignored when sub=1
sub  in  1  0: A+B+cin; 1: A-B (two's complement)
add_a  out  4  nibble of A to the 4-bit adder
add_b  out  4  nibble of B (inverted when sub) to the adder
add_cin  out  1  carry into the adder
add_sum  in  4  adder sum (combinational, same cycle)
add_cout  in  1  adder carry-out (combinational, same cycle)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
cout  out  1  final carry-out (for sub: 1 = no borrow)
ovf  out  1  signed overflow
busy  out  1  high in RUN or DONE

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low (rst_n); all state reacts to rst_n low immediately, independent of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, add_a=0, add_b=0, add_cin=0, index=0, carry=0, operand regs=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On the edge where in_valid&in_ready is high:
  - capture a→a_r and b→b_r.
  - if sub=1, capture ~b.
  - carry ← (sub ? 1 : cin).
  - index ← 0.
  - go to RUN.
- RUN: in_ready=0, busy=1.
  - add_a = a_r[4*index+:4], add_b = b_r[4*index+:4], add_cin = carry (combinational from registers).
  - On each edge: sum_r[4*index+:4] ← add_sum; carry ← add_cout; index ← index+1.
  - On the edge where index==NUM_NIB-1: go to DONE, cout ← add_cout, ovf ← (a_r[W-1]==b_r[W-1]) && (add_sum[3]!=a_r[W-1]). b_r is the already-inverted operand for sub.
- add_a/add_b/add_cin are driven 0 in every state other than RUN.
- DONE: out_valid=1, busy=1; sum/cout/ovf held stable. On the edge where out_valid&out_ready is high: go to IDLE, out_valid←0. sum/cout/ovf keep their last value until the next completion.
- Latency: accept edge at T; out_valid rises after edge T+NUM_NIB (4 cycles at WIDTH=16). Throughput: one operation per NUM_NIB+2 cycles minimum.
- Input handshake rules:
  - in_ready is a pure function of state (=IDLE); it never depends on in_valid.
  - a, b, cin and sub are sampled only on the accept edge; changes afterwards have no effect.
  - in_valid in RUN/DONE is ignored and not queued.
- out_valid, once high, stays high and the result is unchanged until accepted.
- Carry wrap: no carry propagates between operations; carry is re-initialised on every accept.
- Reset mid-RUN or mid-DONE: the operation is discarded with no output and all outputs return to reset values; the first accept is possible on the first edge after rst_n deasserts.

Test Plan:
1. Add: a=16'h1234, b=16'h0FCD, cin=0, sub=0 → 4 cycles later out_valid=1, sum=16'h2201, cout=0, ovf=0; add_cin sequence 0,1,1,1.
2. Add with wrap: a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1, ovf=0. Also a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1.
3. Signed overflow: a=16'h7FFF, b=16'h0001 add → sum=16'h8000, cout=0, ovf=1. Also sub a=16'h8000, b=16'h0001 → sum=16'h7FFF, cout=1, ovf=1.
4. Subtract with borrow: a=16'h0005, b=16'h0007, sub=1, cin=1 (ignored) → sum=16'hFFFE, cout=0, ovf=0. Check add_b nibbles = 4'h8, 4'hF, 4'hF, 4'hF.
5. Backpressure: hold out_ready=0 for 5 cycles after completion → out_valid, sum, cout and ovf stable. in_ready=0 and a pulse on in_valid is not accepted. Then out_ready=1 → in_ready=1 on the next cycle and a new operand is accepted normally.
6. Reset mid-operation: assert rst_n=0 asynchronously at nibble index 2 → all outputs go to reset values immediately without a clock edge. After release, a=16'h0001, b=16'h0001 → sum=16'h0002 with correct latency.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Computes one WIDTH-bit add or subtract by reusing a single external 4-bit
// combinational adder once per nibble, LSB nibble first. The carry between
// nibbles is held in a flop. Operands arrive on a valid/ready handshake and
// the result leaves on a valid/ready handshake.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // operand request
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    // shared 4-bit adder
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    // result
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NUM_NIB = WIDTH / 4;
    localparam int CNT_W   = $clog2(NUM_NIB);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NUM_NIB - 1);

    // Refuse to build with a width the nibble sequencer cannot cover.
    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;       // captured operand A
    logic [WIDTH-1:0] b_r;       // captured operand B, already inverted for sub
    logic [WIDTH-1:0] acc_r;     // partial sum collected nibble by nibble
    logic [WIDTH-1:0] acc_next;  // partial sum including this cycle's nibble
    logic             carry;     // carry into the nibble being processed
    logic [CNT_W-1:0] index;     // nibble currently on the adder

    // Present the current nibble to the shared adder; drive zeros when not running.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_r[4*index +: 4];
            add_b   = b_r[4*index +: 4];
            add_cin = carry;
        end
    end

    // Merge this cycle's adder sum into the partial result.
    always_comb begin
        acc_next                 = acc_r;
        acc_next[4*index +: 4]   = add_sum;
    end

    // Sequencer: accept operands, ripple one nibble per cycle, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            acc_r     <= '0;
            carry     <= 1'b0;
            index     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the values from before this edge.
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= sub ? ~b : b;
                        carry    <= sub ? 1'b1 : cin;
                        acc_r    <= '0;
                        index    <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                RUN: begin
                    acc_r <= acc_next;
                    carry <= add_cout;
                    index <= index + 1'b1;
                    if (index == LAST_NIB) begin
                        state     <= DONE;
                        index     <= '0;
                        sum       <= acc_next;
                        cout      <= add_cout;
                        ovf       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                     (add_sum[3] != a_r[WIDTH-1]);
                        out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl
// Directed and random operations against an arithmetic reference model; the
// shared 4-bit adder is modelled here as plain combinational addition.
module tb_nibble_serial_add_ctrl;

    localparam int W  = 16;
    localparam int NN = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    // DUT-observed results of the most recent operation
    logic [W-1:0] obs_sum;
    logic         obs_cout;
    logic         obs_ovf;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    // The existing 4-bit adder: purely combinational.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic on the whole operands.
    function automatic void model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                  input logic vc, input logic vs,
                                  output logic [W-1:0] es, output logic ec, output logic eo);
        longint ua, ub, sa, sb, sr;
        ua = longint'(va);
        ub = longint'(vb);
        sa = (ua >= (longint'(1) << (W - 1))) ? ua - (longint'(1) << W) : ua;
        sb = (ub >= (longint'(1) << (W - 1))) ? ub - (longint'(1) << W) : ub;
        if (vs) begin
            es = W'(ua - ub);
            ec = (ua >= ub);
            sr = sa - sb;
        end else begin
            es = W'(ua + ub + longint'(vc));
            ec = ((ua + ub + longint'(vc)) >= (longint'(1) << W));
            sr = sa + sb + longint'(vc);
        end
        eo = (sr >= (longint'(1) << (W - 1))) || (sr < -(longint'(1) << (W - 1)));
    endfunction

    // Runs one operation. Call with the simulation away from a rising edge;
    // returns on a falling edge with the block back in IDLE.
    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, input logic vs, input int hold);
        logic [W-1:0] es, eb;
        logic         ec, eo, ecin;
        longint       m;
        model(va, vb, vc, vs, es, ec, eo);
        eb = vs ? ~vb : vb;
        check("in_ready_idle", W'(in_ready), W'(1));
        a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // Operand changes after the accept edge must not matter.
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int i = 0; i < NN; i++) begin
            m = (longint'(1) << (4 * i)) - 1;
            if (vs) ecin = ((longint'(va) & m) >= (longint'(vb) & m));
            else    ecin = (((longint'(va) & m) + (longint'(vb) & m) + longint'(vc)) > m);
            check("add_cin", W'(add_cin), W'(ecin));
            check("add_a", W'(add_a), W'(va[4*i +: 4]));
            check("add_b", W'(add_b), W'(eb[4*i +: 4]));
            check("busy_run", W'(busy), W'(1));
            check("in_ready_run", W'(in_ready), W'(0));
            check("out_valid_run", W'(out_valid), W'(0));
            @(negedge clk);
        end
        check("out_valid_done", W'(out_valid), W'(1));
        check("sum", sum, es);
        check("cout", W'(cout), W'(ec));
        check("ovf", W'(ovf), W'(eo));
        check("add_a_idle_done", W'(add_a), W'(0));
        obs_sum = sum; obs_cout = cout; obs_ovf = ovf;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("hold_out_valid", W'(out_valid), W'(1));
            check("hold_in_ready", W'(in_ready), W'(0));
            check("hold_sum", sum, es);
            check("hold_cout", W'(cout), W'(ec));
            check("hold_ovf", W'(ovf), W'(eo));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after", W'(out_valid), W'(0));
        check("in_ready_after", W'(in_ready), W'(1));
        check("busy_after", W'(busy), W'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, W'(in_ready), W'(1));
        check({tag, "_out_valid"}, W'(out_valid), W'(0));
        check({tag, "_busy"}, W'(busy), W'(0));
        check({tag, "_sum"}, sum, W'(0));
        check({tag, "_cout"}, W'(cout), W'(0));
        check({tag, "_ovf"}, W'(ovf), W'(0));
        check({tag, "_add_a"}, W'(add_a), W'(0));
        check({tag, "_add_b"}, W'(add_b), W'(0));
        check({tag, "_add_cin"}, W'(add_cin), W'(0));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        #4 rst_n = 1'b1;

        // Plain add; first accept on the first edge after reset release
        do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0);
        check("t1_sum", obs_sum, 16'h2201);
        check("t1_cout", W'(obs_cout), W'(0));

        // Wrap-around adds
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        check("t2a_sum", obs_sum, 16'h0000);
        check("t2a_cout", W'(obs_cout), W'(1));
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1);
        check("t2b_sum", obs_sum, 16'h0000);
        check("t2b_cout", W'(obs_cout), W'(1));

        // Signed overflow
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        check("t3a_sum", obs_sum, 16'h8000);
        check("t3a_ovf", W'(obs_ovf), W'(1));
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        check("t3b_sum", obs_sum, 16'h7FFF);
        check("t3b_cout", W'(obs_cout), W'(1));
        check("t3b_ovf", W'(obs_ovf), W'(1));

        // Subtract with borrow; cin is ignored
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        check("t4_sum", obs_sum, 16'hFFFE);
        check("t4_cout", W'(obs_cout), W'(0));
        check("t4_ovf", W'(obs_ovf), W'(0));

        // Backpressure with in_valid pulses during DONE, then a normal op
        do_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 5);
        do_op(16'h0100, 16'h00FF, 1'b1, 1'b0, 0);

        // Asynchronous reset at nibble index 2
        a = 16'h5A5A; b = 16'h3C3C; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", W'(busy), W'(1));
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        #1 rst_n = 1'b1;
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
        check("t6_sum", obs_sum, 16'h0002);

        // Random operations with random backpressure
        for (int n = 0; n < 24; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
